e_alloc: RTL

//   Registered W-slot allocator built on circular find-first-zero search.

---
 rtl/e_alloc.sv | 107 ++++++++++
 1 files changed

// File: rtl/e_alloc.sv
// Registered W-slot allocator: circular find-first-zero over a busy vector,
// with an optional round-robin search pointer and a sticky illegal-free flag.
module e_alloc #(
  parameter int W     = 32,
  parameter int RR_EN = 1,
  parameter int IW    = $clog2(W),
  parameter int CW    = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_vld_i,
  output logic          alloc_rdy_o,
  output logic [IW-1:0] alloc_id_o,
  input  logic          free_vld_i,
  input  logic [IW-1:0] free_id_i,
  output logic [W-1:0]  busy_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  localparam logic [IW:0]   W_X     = (IW + 1)'(W);
  localparam logic [IW-1:0] LAST_ID = IW'(W - 1);
  localparam logic [CW-1:0] W_C     = CW'(W);

  logic [W-1:0]  busy_q, busy_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          err_q, err_d;

  logic [IW-1:0] grant_id;
  logic [IW:0]   search_idx;
  logic          fire;
  logic          free_in_range;
  logic          free_legal;
  logic          free_bad;

  // Search walks the ring from the far end back toward ptr, so the last free
  // slot written is the first one met in ptr, ptr+1, ..., ptr-1 order.
  always_comb begin
    grant_id   = '0;
    search_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      search_idx = {1'b0, ptr_q} + (IW + 1)'(i);
      if (search_idx >= W_X) search_idx = search_idx - W_X;
      if (!busy_q[search_idx[IW-1:0]]) grant_id = search_idx[IW-1:0];
    end
  end

  // Handshake: an allocation transfers in any cycle where alloc_vld_i and
  // alloc_rdy_o are both high; alloc_id_o is the slot taken in that cycle.
  // A requester seeing alloc_rdy_o low simply holds alloc_vld_i. Frees have
  // no ready and are always consumed in the cycle they are presented.
  assign fire          = alloc_vld_i && !full_q;
  assign free_in_range = (free_id_i <= LAST_ID);
  assign free_legal    = free_vld_i && free_in_range && busy_q[free_id_i];
  assign free_bad      = free_vld_i && !free_legal;

  always_comb begin
    busy_d = busy_q;
    if (fire)       busy_d[grant_id]  = 1'b1;
    if (free_legal) busy_d[free_id_i] = 1'b0;

    ptr_d = ptr_q;
    if (RR_EN != 0 && fire) ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);

    case ({fire, free_legal})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == W_C);
    empty_d = (count_d == '0);
    err_d   = err_q | free_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign alloc_rdy_o = !full_q;
  assign alloc_id_o  = grant_id;
  assign busy_o      = busy_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign err_o       = err_q;

endmodule
